// File: rtl/uart_fifo_tx_pkg.sv
// Shared constants for the UART FIFO transmitter: FSM encoding, baud presets, line idle level.
package uart_fifo_tx_pkg;

  // Transmit FSM states (3-bit encoding)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  // Clock cycles per bit for a 100 MHz system clock
  localparam int unsigned CLKS_115200_AT_100MHZ = 868;
  localparam int unsigned CLKS_100HZ_AT_100MHZ  = 1_000_000;
  localparam int unsigned CLKS_1HZ_AT_100MHZ    = 100_000_000;

  // Level driven on the serial line when nothing is being sent
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_fifo_tx_baud_tick_gen.sv
// Bit-period counter: one-cycle tick on the last cycle of every CLKS_PER_BIT window.
module uart_fifo_tx_baud_tick_gen
  import uart_fifo_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_115200_AT_100MHZ
) (
  input  logic clk_fpga,
  input  logic nreset,
  input  logic i_clear,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  assign o_tick_c = (r_count == CNT_LAST);

  // Free-running count, wraps at the bit boundary, restarts on a sync clear
  always_ff @(posedge clk_fpga or negedge nreset) begin
    if (!nreset) begin
      r_count <= '0;
    end else if (i_clear || o_tick_c) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// Pops words from the UART data FIFO and serializes them: start, LSB-first data, optional parity, stop.
module uart_fifo_tx
  import uart_fifo_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_115200_AT_100MHZ,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FIFO_W       = 3,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic              clk_fpga,
  input  logic              nreset,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [FIFO_W-1:0] fifo_rd_data,
  input  logic              tx_enable,
  output logic              uart_txd,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic              r_parity;
  logic              w_parity_next;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [IDX_W-1:0]  w_bit_idx_next;
  logic              r_txd;
  logic              w_txd_next;
  logic              r_rd_en;
  logic              w_rd_en_next;
  logic              r_busy;
  logic              w_busy_next;
  logic              r_done;
  logic              w_done_next;
  logic              w_tick;
  logic              w_state_chg;

  // Baud counter restarts whenever the FSM moves to a new state
  assign w_state_chg = (w_next_state != r_state);

  uart_fifo_tx_baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_fpga (clk_fpga),
    .nreset   (nreset),
    .i_clear  (w_state_chg),
    .o_tick_c (w_tick)
  );

  // State register
  always_ff @(posedge clk_fpga or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, datapath updates and next output values
  always_comb begin
    w_next_state   = r_state;
    w_shift_next   = r_shift;
    w_parity_next  = r_parity;
    w_bit_idx_next = r_bit_idx;
    w_rd_en_next   = 1'b0;
    w_done_next    = 1'b0;
    w_txd_next     = IDLE_LEVEL;

    case (r_state)
      ST_IDLE: begin
        if (tx_enable && !fifo_empty) begin
          w_rd_en_next = 1'b1;
          w_next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        w_shift_next  = DATA_W'(fifo_rd_data);
        w_parity_next = ^fifo_rd_data;
        w_next_state  = ST_START;
      end
      ST_START: begin
        w_txd_next = 1'b0;
        if (w_tick) begin
          w_bit_idx_next = '0;
          w_next_state   = ST_DATA;
        end
      end
      ST_DATA: begin
        w_txd_next = r_shift[0];
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == IDX_LAST) begin
            w_next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        w_txd_next = r_parity;
        if (w_tick) begin
          w_next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        w_txd_next = 1'b1;
        if (w_tick) begin
          w_done_next  = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // Busy spans the pop strobe through the final stop-bit cycle on the line
    w_busy_next = (w_next_state != ST_IDLE) || w_done_next;
  end

  // Datapath and output registers; the line lags the FSM by one cycle
  always_ff @(posedge clk_fpga or negedge nreset) begin
    if (!nreset) begin
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit_idx <= '0;
      r_txd     <= IDLE_LEVEL;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_shift   <= w_shift_next;
      r_parity  <= w_parity_next;
      r_bit_idx <= w_bit_idx_next;
      r_txd     <= w_txd_next;
      r_rd_en   <= w_rd_en_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
    end
  end

  assign uart_txd   = r_txd;
  assign fifo_rd_en = r_rd_en;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: two instances (no parity / even parity) fed by 1-cycle-latency FIFO models,
// line waveform compared against a bit-list frame model.
module tb_uart_fifo_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;
  localparam int FW  = 8;
  localparam int SEG = 3 + (2 + DW) * CPB;

  logic clk_fpga  = 1'b0;
  logic nreset    = 1'b1;
  logic tx_enable = 1'b0;

  logic          fifo_empty   = 1'b1;
  logic [FW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en, uart_txd, tx_busy, tx_done;

  logic          p_fifo_empty   = 1'b1;
  logic [FW-1:0] p_fifo_rd_data = '0;
  logic          p_fifo_rd_en, p_uart_txd, p_tx_busy, p_tx_done;

  int checks = 0;
  int errors = 0;
  int pops0 = 0;
  int pops1 = 0;
  int underflow = 0;

  logic [FW-1:0] fq[$];
  logic [FW-1:0] pq[$];
  logic lg_txd[$], lg_rd[$], lg_done[$], lg_busy[$];
  logic plg_txd[$], plg_rd[$], plg_done[$], plg_busy[$];
  logic ex_txd[$], ex_rd[$], ex_done[$], ex_busy[$];

  always #5 clk_fpga = ~clk_fpga;

  uart_fifo_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .FIFO_W(FW), .PARITY_EN(0)) u_dut (
    .clk_fpga(clk_fpga), .nreset(nreset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .tx_enable(tx_enable), .uart_txd(uart_txd),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_fifo_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .FIFO_W(FW), .PARITY_EN(1)) u_dut_p (
    .clk_fpga(clk_fpga), .nreset(nreset), .fifo_empty(p_fifo_empty), .fifo_rd_en(p_fifo_rd_en),
    .fifo_rd_data(p_fifo_rd_data), .tx_enable(tx_enable), .uart_txd(p_uart_txd),
    .tx_busy(p_tx_busy), .tx_done(p_tx_done)
  );

  // One clock: FIFO models answer last cycle's pop, then both DUTs' outputs are logged
  task automatic cycle();
    logic rd0, rd1;
    rd0 = fifo_rd_en;
    rd1 = p_fifo_rd_en;
    @(posedge clk_fpga);
    #1;
    if (rd0 === 1'b1) begin
      pops0++;
      if (fq.size() == 0) underflow++;
      else fifo_rd_data = fq.pop_front();
    end
    if (rd1 === 1'b1) begin
      pops1++;
      if (pq.size() == 0) underflow++;
      else p_fifo_rd_data = pq.pop_front();
    end
    fifo_empty   = (fq.size() == 0);
    p_fifo_empty = (pq.size() == 0);
    lg_txd.push_back(uart_txd);    lg_rd.push_back(fifo_rd_en);
    lg_done.push_back(tx_done);    lg_busy.push_back(tx_busy);
    plg_txd.push_back(p_uart_txd); plg_rd.push_back(p_fifo_rd_en);
    plg_done.push_back(p_tx_done); plg_busy.push_back(p_tx_busy);
  endtask

  task automatic clear_logs();
    lg_txd.delete();  lg_rd.delete();  lg_done.delete();  lg_busy.delete();
    plg_txd.delete(); plg_rd.delete(); plg_done.delete(); plg_busy.delete();
    ex_txd.delete();  ex_rd.delete();  ex_done.delete();  ex_busy.delete();
    pops0 = 0;
    pops1 = 0;
    underflow = 0;
  endtask

  // Expected per-cycle activity for one word, starting at its pop cycle:
  // three idle-high cycles, then each frame bit held for CPB cycles; done on the very last cycle.
  function automatic void model_frame(input logic [DW-1:0] w, input bit par);
    logic bits[$];
    int ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      bits.push_back(w[i]);
      if (w[i]) ones++;
    end
    if (par) bits.push_back((ones % 2) == 1);
    bits.push_back(1'b1);
    for (int i = 0; i < 3; i++) begin
      ex_txd.push_back(1'b1); ex_rd.push_back(i == 0); ex_done.push_back(1'b0); ex_busy.push_back(1'b1);
    end
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < CPB; c++) begin
        ex_txd.push_back(bits[b]);
        ex_rd.push_back(1'b0);
        ex_done.push_back((b == bits.size() - 1) && (c == CPB - 1));
        ex_busy.push_back(1'b1);
      end
    end
  endfunction

  task automatic test_reset();
    nreset = 1'b1;
    #2 nreset = 1'b0;
    tx_enable = 1'b1;
    fq.push_back(8'h11);
    fifo_empty = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if ({uart_txd, fifo_rd_en, tx_busy, tx_done} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d txd/rd/busy/done got %b%b%b%b exp 1000",
                 i, uart_txd, fifo_rd_en, tx_busy, tx_done);
      end
    end
    fq.delete();
    fifo_empty = 1'b1;
    nreset = 1'b1;
    clear_logs();
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (pops0 !== 0 || uart_txd !== 1'b1) begin
      errors++;
      $display("FAIL reset_release pops %0d txd %b exp pops 0 txd 1", pops0, uart_txd);
    end
  endtask

  task automatic test_single_frame();
    int p, k, bad, s, d;
    logic [3:0] got, exp, bg, be;
    clear_logs();
    model_frame(8'hA5, 1'b0);
    fq.push_back(8'hA5);
    fifo_empty = 1'b0;
    tx_enable = 1'b1;
    for (int i = 0; i < SEG + 20; i++) cycle();
    checks++;
    if (pops0 !== 1) begin errors++; $display("FAIL single_pops got %0d exp 1", pops0); end
    p = -1;
    foreach (lg_rd[i]) if (p < 0 && lg_rd[i] === 1'b1) p = i;
    if (p < 0) p = 0;
    bad = -1; bg = '0; be = '0;
    for (int j = 0; j < ex_txd.size(); j++) begin
      k = p + j;
      got = (k < lg_txd.size()) ? {lg_txd[k], lg_rd[k], lg_done[k], lg_busy[k]} : 4'bxxxx;
      exp = {ex_txd[j], ex_rd[j], ex_done[j], ex_busy[j]};
      if (bad < 0 && got !== exp) begin bad = j; bg = got; be = exp; end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL single_wave cyc +%0d txd/rd/done/busy got %b exp %b", bad, bg, be);
    end
    s = -1; d = -1;
    for (int i = p; i < lg_txd.size(); i++) begin
      if (s < 0 && lg_txd[i] === 1'b0) s = i;
      if (d < 0 && lg_done[i] === 1'b1) d = i;
    end
    checks++;
    if (d - s + 1 != (2 + DW) * CPB) begin
      errors++;
      $display("FAIL single_len got %0d exp %0d", d - s + 1, (2 + DW) * CPB);
    end
    checks++;
    if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_tail txd %b busy %b exp 1 0", uart_txd, tx_busy);
    end
  endtask

  task automatic test_parity();
    int p, k, bad, s, d;
    logic [3:0] got, exp, bg, be;
    logic [FW-1:0] w;
    clear_logs();
    model_frame(8'h07, 1'b1);
    pq.push_back(8'h07);
    for (int i = 0; i < 2; i++) begin
      w = 8'($urandom_range(255, 0));
      pq.push_back(w);
      model_frame(w, 1'b1);
    end
    p_fifo_empty = 1'b0;
    tx_enable = 1'b1;
    for (int i = 0; i < ex_txd.size() + 20; i++) cycle();
    checks++;
    if (pops1 !== 3 || underflow !== 0) begin
      errors++;
      $display("FAIL parity_pops got %0d underflow %0d exp 3 0", pops1, underflow);
    end
    p = -1;
    foreach (plg_rd[i]) if (p < 0 && plg_rd[i] === 1'b1) p = i;
    if (p < 0) p = 0;
    bad = -1; bg = '0; be = '0;
    for (int j = 0; j < ex_txd.size(); j++) begin
      k = p + j;
      got = (k < plg_txd.size()) ? {plg_txd[k], plg_rd[k], plg_done[k], plg_busy[k]} : 4'bxxxx;
      exp = {ex_txd[j], ex_rd[j], ex_done[j], ex_busy[j]};
      if (bad < 0 && got !== exp) begin bad = j; bg = got; be = exp; end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL parity_wave cyc +%0d txd/rd/done/busy got %b exp %b", bad, bg, be);
    end
    s = -1; d = -1;
    for (int i = p; i < plg_txd.size(); i++) begin
      if (s < 0 && plg_txd[i] === 1'b0) s = i;
      if (d < 0 && plg_done[i] === 1'b1) d = i;
    end
    checks++;
    if (d - s + 1 != (3 + DW) * CPB) begin
      errors++;
      $display("FAIL parity_len got %0d exp %0d", d - s + 1, (3 + DW) * CPB);
    end
  endtask

  // Back-to-back stream; fixed words 1,2,3 or a random burst
  task automatic test_back_to_back(input bit rnd);
    int p, k, bad, d1, s2, n;
    logic [3:0] got, exp, bg, be;
    logic [FW-1:0] w;
    clear_logs();
    n = rnd ? 5 : 3;
    for (int i = 0; i < n; i++) begin
      w = rnd ? 8'($urandom_range(255, 0)) : 8'(i + 1);
      fq.push_back(w);
      model_frame(w, 1'b0);
    end
    fifo_empty = 1'b0;
    tx_enable = 1'b1;
    for (int i = 0; i < ex_txd.size() + 30; i++) cycle();
    checks++;
    if (pops0 !== n || underflow !== 0) begin
      errors++;
      $display("FAIL b2b_pops got %0d underflow %0d exp %0d 0", pops0, underflow, n);
    end
    p = -1;
    foreach (lg_rd[i]) if (p < 0 && lg_rd[i] === 1'b1) p = i;
    if (p < 0) p = 0;
    bad = -1; bg = '0; be = '0;
    for (int j = 0; j < ex_txd.size(); j++) begin
      k = p + j;
      got = (k < lg_txd.size()) ? {lg_txd[k], lg_rd[k], lg_done[k], lg_busy[k]} : 4'bxxxx;
      exp = {ex_txd[j], ex_rd[j], ex_done[j], ex_busy[j]};
      if (bad < 0 && got !== exp) begin bad = j; bg = got; be = exp; end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL b2b_wave rnd %0d cyc +%0d txd/rd/done/busy got %b exp %b", rnd, bad, bg, be);
    end
    d1 = -1; s2 = -1;
    for (int i = p; i < lg_txd.size(); i++) begin
      if (d1 < 0 && lg_done[i] === 1'b1) d1 = i;
      if (d1 >= 0 && i > d1 && s2 < 0 && lg_txd[i] === 1'b0) s2 = i;
    end
    checks++;
    if (s2 - d1 - 1 != 3) begin
      errors++;
      $display("FAIL b2b_gap got %0d idle cycles exp 3", s2 - d1 - 1);
    end
  endtask

  task automatic test_enable_drop();
    int p, k, bad, late;
    logic [3:0] got, exp, bg, be;
    logic [FW-1:0] w;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      w = 8'($urandom_range(255, 0));
      fq.push_back(w);
      if (i == 0) model_frame(w, 1'b0);
    end
    fifo_empty = 1'b0;
    tx_enable = 1'b1;
    p = -1;
    for (int i = 0; i < 2 * SEG + 40; i++) begin
      cycle();
      if (p < 0 && lg_rd[lg_rd.size() - 1] === 1'b1) p = lg_rd.size() - 1;
      if (p >= 0 && lg_rd.size() - 1 == p + 20) tx_enable = 1'b0;
    end
    if (p < 0) p = 0;
    bad = -1; bg = '0; be = '0;
    for (int j = 0; j < ex_txd.size(); j++) begin
      k = p + j;
      got = (k < lg_txd.size()) ? {lg_txd[k], lg_rd[k], lg_done[k], lg_busy[k]} : 4'bxxxx;
      exp = {ex_txd[j], ex_rd[j], ex_done[j], ex_busy[j]};
      if (bad < 0 && got !== exp) begin bad = j; bg = got; be = exp; end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL endrop_wave cyc +%0d txd/rd/done/busy got %b exp %b", bad, bg, be);
    end
    late = 0;
    for (int i = p + 1; i < lg_rd.size(); i++) if (lg_rd[i] !== 1'b0) late++;
    checks++;
    if (pops0 !== 1 || late !== 0 || fq.size() !== 2) begin
      errors++;
      $display("FAIL endrop_pops pops %0d late %0d left %0d exp 1 0 2", pops0, late, fq.size());
    end
    fq.delete();
    fifo_empty = 1'b1;
    tx_enable = 1'b1;
  endtask

  task automatic test_reset_midframe();
    int p, k, bad, n;
    logic [3:0] got, exp, bg, be;
    clear_logs();
    fq.push_back(8'h55);
    fq.push_back(8'h3C);
    fifo_empty = 1'b0;
    tx_enable = 1'b1;
    p = -1;
    n = 0;
    while (n < SEG && !(p >= 0 && lg_rd.size() - 1 == p + 28)) begin
      cycle();
      n++;
      if (p < 0 && lg_rd[lg_rd.size() - 1] === 1'b1) p = lg_rd.size() - 1;
    end
    checks++;
    if (p < 0 || uart_txd !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_bit5 pop %0d txd %b exp pop seen, txd 0", p, uart_txd);
    end
    #2 nreset = 1'b0;
    #1;
    checks++;
    if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async txd/busy/rd got %b%b%b exp 100", uart_txd, tx_busy, fifo_rd_en);
    end
    cycle();
    cycle();
    nreset = 1'b1;
    clear_logs();
    model_frame(8'h3C, 1'b0);
    for (int i = 0; i < SEG + 20; i++) cycle();
    p = -1;
    foreach (lg_rd[i]) if (p < 0 && lg_rd[i] === 1'b1) p = i;
    if (p < 0) p = 0;
    bad = -1; bg = '0; be = '0;
    for (int j = 0; j < ex_txd.size(); j++) begin
      k = p + j;
      got = (k < lg_txd.size()) ? {lg_txd[k], lg_rd[k], lg_done[k], lg_busy[k]} : 4'bxxxx;
      exp = {ex_txd[j], ex_rd[j], ex_done[j], ex_busy[j]};
      if (bad < 0 && got !== exp) begin bad = j; bg = got; be = exp; end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL rstmid_wave cyc +%0d txd/rd/done/busy got %b exp %b", bad, bg, be);
    end
    checks++;
    if (pops0 !== 1 || fq.size() !== 0 || underflow !== 0) begin
      errors++;
      $display("FAIL rstmid_pops pops %0d left %0d underflow %0d exp 1 0 0", pops0, fq.size(), underflow);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_enable_drop();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
